// File: rtl/snake_pkg.sv
// Shared codes for the snake move scheduler: direction and game-status encodings,
// scheduler FSM states and the direction-reversal helper.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [1:0] ST_RESTART = 2'b00;
  localparam logic [1:0] ST_START   = 2'b01;
  localparam logic [1:0] ST_PLAY    = 2'b10;
  localparam logic [1:0] ST_DIE     = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StTick,
    StReq,
    StWaitDone
  } sched_state_e;

  // Opposite direction: up<->down, left<->right.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_dir_arb.sv
// Key arbiter: rising-edge detect on the four direction keys, fixed priority
// key1 > key2 > key3 > key4, reversal filter against the committed direction.
// The surviving request is held in pend_dir until the scheduler commits it.
module snake_dir_arb
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key1,
  input  logic       key2,
  input  logic       key3,
  input  logic       key4,
  input  logic [1:0] dir,
  input  logic       upd_en,
  input  logic       clr,
  output logic [1:0] pend_dir
);

  logic [3:0] keys;
  logic [3:0] keys_q;
  logic [3:0] key_rise;
  logic [1:0] cand;
  logic [1:0] pend_q;
  logic [1:0] pend_d;

  assign keys = {key4, key3, key2, key1};

  // Previous key levels for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q <= 4'b0000;
    end else begin
      keys_q <= keys;
    end
  end

  // Priority pick among new edges, then drop a request that would reverse the snake.
  always_comb begin
    key_rise = keys & ~keys_q;
    if (key_rise[0]) begin
      cand = DIR_UP;
    end else if (key_rise[1]) begin
      cand = DIR_DOWN;
    end else if (key_rise[2]) begin
      cand = DIR_LEFT;
    end else begin
      cand = DIR_RIGHT;
    end

    pend_d = pend_q;
    if (clr) begin
      pend_d = DIR_RIGHT;
    end else if (upd_en && (key_rise != 4'b0000) && (cand != reverse_dir(dir))) begin
      pend_d = cand;
    end
  end

  // Pending direction register; last accepted edge between steps wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= DIR_RIGHT;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_dir = pend_q;

endmodule

// File: rtl/snake_move_sched.sv
// Snake step scheduler: times each move from a speed-dependent period, commits the
// arbitrated key direction once per step and runs a req/ack handshake with the body
// datapath, with an ack timeout. Active only while the game status is PLAY.
// Optional feature macro SNAKE_PAUSE_EN adds pause_key input and paused output.
module snake_move_sched
  import snake_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 12_500_000,
  parameter int unsigned STEP_DEC    = 1_000_000,
  parameter int unsigned MIN_PERIOD  = 3_125_000,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SNAKE_PAUSE_EN
  input  logic        pause_key,
  output logic        paused,
`endif
  input  logic [1:0]  status,
  input  logic        key1,
  input  logic        key2,
  input  logic        key3,
  input  logic        key4,
  input  logic [15:0] point,
  input  logic        move_done,
  output logic        move_req,
  output logic [1:0]  dir,
  output logic [3:0]  speed_lvl,
  output logic [15:0] step_cnt,
  output logic        stall_err
);

  localparam int unsigned AckW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  sched_state_e state_q, state_d;
  logic [31:0]     timer_q, timer_d;
  logic [31:0]     period_q, period_d;
  logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
  logic            move_req_q, move_req_d;
  logic [1:0]      dir_q, dir_d;
  logic [15:0]     step_cnt_q, step_cnt_d;
  logic            stall_err_q, stall_err_d;
  logic [3:0]      speed_lvl_q, speed_lvl_d;

  logic [31:0] dec_amt;
  logic [31:0] period_calc;
  logic [1:0]  pend_dir;
  logic        run_en;
  logic        unused_point;

  // Only the tens digit of the score drives the speed.
  assign unused_point = ^{point[15:8], point[3:0]};

`ifdef SNAKE_PAUSE_EN
  logic pause_key_q;
  logic paused_q, paused_d;

  // Pause toggles on a pause_key edge during PLAY and is dropped whenever PLAY is left.
  always_comb begin
    paused_d = paused_q;
    if (status != ST_PLAY) begin
      paused_d = 1'b0;
    end else if (pause_key && !pause_key_q) begin
      paused_d = ~paused_q;
    end
  end

  // Pause key edge stage and paused flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_key_q <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      pause_key_q <= pause_key;
      paused_q    <= paused_d;
    end
  end

  assign run_en = ~paused_q;
  assign paused = paused_q;
`else
  assign run_en = 1'b1;
`endif

  snake_dir_arb u_dir_arb (
    .clk      (clk),
    .rst      (rst),
    .key1     (key1),
    .key2     (key2),
    .key3     (key3),
    .key4     (key4),
    .dir      (dir_q),
    .upd_en   (run_en),
    .clr      (status == ST_RESTART),
    .pend_dir (pend_dir)
  );

  // Step period from the registered speed level; clamp is decided before subtracting.
  always_comb begin
    dec_amt     = 32'(speed_lvl_q) * STEP_DEC;
    speed_lvl_d = (point[7:4] > 4'd9) ? 4'd9 : point[7:4];
    if ((BASE_PERIOD <= MIN_PERIOD) || (dec_amt >= BASE_PERIOD - MIN_PERIOD)) begin
      period_calc = MIN_PERIOD;
    end else begin
      period_calc = BASE_PERIOD - dec_amt;
    end
  end

  // Scheduler next-state and output logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    period_d    = period_q;
    ack_cnt_d   = ack_cnt_q;
    move_req_d  = move_req_q;
    dir_d       = dir_q;
    step_cnt_d  = step_cnt_q;
    stall_err_d = 1'b0;

    if (status != ST_PLAY) begin
      // Leaving PLAY aborts any outstanding request; dir is kept unless restarting.
      state_d    = StIdle;
      move_req_d = 1'b0;
      timer_d    = '0;
      ack_cnt_d  = '0;
      if (status == ST_RESTART) begin
        dir_d      = DIR_RIGHT;
        step_cnt_d = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StTick;
          timer_d  = '0;
          period_d = period_calc;
        end
        StTick: begin
          if (run_en) begin
            if (timer_q == period_q - 32'd1) begin
              state_d = StReq;
              timer_d = '0;
              dir_d   = pend_dir;
            end else begin
              timer_d = timer_q + 32'd1;
            end
          end
        end
        StReq, StWaitDone: begin
          if (move_done) begin
            state_d    = StTick;
            move_req_d = 1'b0;
            timer_d    = '0;
            period_d   = period_calc;
            if (step_cnt_q != 16'hFFFF) begin
              step_cnt_d = step_cnt_q + 16'd1;
            end
          end else if (state_q == StReq) begin
            state_d    = StWaitDone;
            move_req_d = 1'b1;
            ack_cnt_d  = '0;
          end else if (ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
            state_d     = StTick;
            move_req_d  = 1'b0;
            stall_err_d = 1'b1;
            timer_d     = '0;
            period_d    = period_calc;
          end else begin
            ack_cnt_d = ack_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      period_q    <= BASE_PERIOD;
      ack_cnt_q   <= '0;
      move_req_q  <= 1'b0;
      dir_q       <= DIR_RIGHT;
      step_cnt_q  <= '0;
      stall_err_q <= 1'b0;
      speed_lvl_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      ack_cnt_q   <= ack_cnt_d;
      move_req_q  <= move_req_d;
      dir_q       <= dir_d;
      step_cnt_q  <= step_cnt_d;
      stall_err_q <= stall_err_d;
      speed_lvl_q <= speed_lvl_d;
    end
  end

  assign move_req  = move_req_q;
  assign dir       = dir_q;
  assign speed_lvl = speed_lvl_q;
  assign step_cnt  = step_cnt_q;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_snake_move_sched.sv
// Bench for snake_move_sched with a short period: expected directions are queued when
// keys are driven and popped when each move request appears.
module tb_snake_move_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  status = 2'b10;
  logic        key1 = 1'b0;
  logic        key2 = 1'b0;
  logic        key3 = 1'b0;
  logic        key4 = 1'b0;
  logic [15:0] point = 16'h0000;
  logic        move_done = 1'b0;
  logic        move_req;
  logic [1:0]  dir;
  logic [3:0]  speed_lvl;
  logic [15:0] step_cnt;
  logic        stall_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rise;
  int exp_steps;
  int t0;
  int hi_cnt;
  logic [1:0] exp_q[$];

  snake_move_sched #(
    .BASE_PERIOD (100),
    .STEP_DEC    (10),
    .MIN_PERIOD  (30),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .status    (status),
    .key1      (key1),
    .key2      (key2),
    .key3      (key3),
    .key4      (key4),
    .point     (point),
    .move_done (move_done),
    .move_req  (move_req),
    .dir       (dir),
    .speed_lvl (speed_lvl),
    .step_cnt  (step_cnt),
    .stall_err (stall_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for move_req to be seen high at a falling edge; t = cycle or -1.
  task automatic wait_rise(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (move_req) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("req_timeout", 32'(move_req), 32'd1);
  endtask

  // One step: check spacing and scoreboard direction, optionally ack two cycles later.
  task automatic step(input int exp_gap, input bit do_ack);
    int t;
    wait_rise(t);
    if (t < 0) return;
    check("req_gap", 32'(t - last_rise), 32'(exp_gap));
    last_rise = t;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      check("dir", 32'(dir), 32'(exp_q.pop_front()));
    end
    if (do_ack) begin
      @(negedge clk);
      move_done = 1'b1;
      @(negedge clk);
      move_done = 1'b0;
      exp_steps++;
      check("req_drop", 32'(move_req), 32'd0);
      check("step_cnt", 32'(step_cnt), 32'(exp_steps));
    end
  endtask

  task automatic key_pulse(input logic [3:0] k);
    {key4, key3, key2, key1} = k;
    repeat (2) @(negedge clk);
    {key4, key3, key2, key1} = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    exp_steps = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_move_req", 32'(move_req), 32'd0);
    check("rst_dir", 32'(dir), 32'd3);
    check("rst_speed", 32'(speed_lvl), 32'd0);
    check("rst_step_cnt", 32'(step_cnt), 32'd0);
    check("rst_stall", 32'(stall_err), 32'd0);

    // Basic stepping: first request period+1 after IDLE->TICK, then period+3 with ack.
    rst = 1'b0;
    t0 = cyc;
    last_rise = t0;
    exp_q.push_back(2'b11);
    step(102, 1'b1);
    exp_q.push_back(2'b11);
    step(103, 1'b1);

    // Reversal (left while moving right) is ignored; up is taken.
    key_pulse(4'b0100);
    exp_q.push_back(2'b11);
    step(103, 1'b1);
    key_pulse(4'b0001);
    exp_q.push_back(2'b00);
    step(103, 1'b1);

    // Down (reversal) then left within one step -> left.
    key_pulse(4'b0010);
    key_pulse(4'b0100);
    exp_q.push_back(2'b10);
    step(103, 1'b1);

    // Up and right together -> up has priority.
    key_pulse(4'b1001);
    exp_q.push_back(2'b00);
    step(103, 1'b1);

    // Speed level from tens digit with clamp; new period only at next TICK entry.
    point = 16'h0045;
    repeat (2) @(negedge clk);
    check("speed_4", 32'(speed_lvl), 32'd4);
    point = 16'h00A0;
    repeat (2) @(negedge clk);
    check("speed_clamp", 32'(speed_lvl), 32'd9);
    point = 16'h0090;
    repeat (2) @(negedge clk);
    check("speed_9", 32'(speed_lvl), 32'd9);
    exp_q.push_back(2'b00);
    step(103, 1'b1);
    exp_q.push_back(2'b00);
    step(33, 1'b1);

    // Ack timeout: req held 8 cycles, one-cycle stall_err, no step count.
    exp_q.push_back(2'b00);
    step(33, 1'b0);
    hi_cnt = 0;
    while (move_req && hi_cnt < 50) begin
      hi_cnt++;
      @(negedge clk);
    end
    check("timeout_len", 32'(hi_cnt), 32'd8);
    check("stall_pulse", 32'(stall_err), 32'd1);
    check("stall_steps", 32'(step_cnt), 32'(exp_steps));
    @(negedge clk);
    check("stall_clear", 32'(stall_err), 32'd0);
    exp_q.push_back(2'b00);
    step(39, 1'b1);

    // PLAY -> DIE while waiting for ack, then RESTART clears dir and step count.
    key_pulse(4'b0100);
    exp_q.push_back(2'b10);
    step(33, 1'b0);
    status = 2'b11;
    @(negedge clk);
    check("die_req_drop", 32'(move_req), 32'd0);
    repeat (50) @(negedge clk);
    check("die_idle_req", 32'(move_req), 32'd0);
    check("die_dir_held", 32'(dir), 32'd2);
    check("die_steps", 32'(step_cnt), 32'(exp_steps));
    status = 2'b00;
    @(negedge clk);
    check("restart_dir", 32'(dir), 32'd3);
    check("restart_steps", 32'(step_cnt), 32'd0);
    exp_steps = 0;
    status = 2'b10;
    t0 = cyc;
    last_rise = t0;
    exp_q.push_back(2'b11);
    step(32, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
